// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer
//   Walks the enabled ADC channels of a frame in ascending order. For each
//   channel: select the analog mux, wait for it to settle, pulse the SAR
//   start, wait for end-of-conversion (or a timeout), then present the
//   result to the FIFO for one cycle.
//
// Ports
//   SAMPLE_CLK    in   sole clock, rising edge
//   NRST_sync     in   asynchronous active-low reset
//   ENSAMP_sync   in   sampling enable; low aborts any frame to IDLE
//   FRAME_TRIG    in   single-cycle frame-start tick
//   CHEN[7:0]     in   channel enable mask, latched at frame start
//   ADC_EOC       in   SAR end-of-conversion strobe
//   ADC_DOUT[15:0] in  SAR result, valid with ADC_EOC
//   ADC_START     out  single-cycle conversion start pulse
//   ATMCHSEL[7:0] out  one-hot mux / FIFO word select (0 when idle)
//   RESULT[15:0]  out  conversion result (16'hFFFF on timeout)
//   DONE          out  single-cycle result-valid strobe
//   LASTWORD      out  with DONE on the last enabled channel of the frame
//   SEQ_BUSY      out  high whenever not IDLE
//   FRAME_MISSED  out  toggles once per FRAME_TRIG dropped while busy
//   ADC_TIMEOUT   out  toggles once per conversion timeout
module adc_channel_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned CONV_TIMEOUT  = 64
) (
   input  logic        SAMPLE_CLK,
   input  logic        NRST_sync,
   input  logic        ENSAMP_sync,
   input  logic        FRAME_TRIG,
   input  logic [7:0]  CHEN,
   input  logic        ADC_EOC,
   input  logic [15:0] ADC_DOUT,
   output logic        ADC_START,
   output logic [7:0]  ATMCHSEL,
   output logic [15:0] RESULT,
   output logic        DONE,
   output logic        LASTWORD,
   output logic        SEQ_BUSY,
   output logic        FRAME_MISSED,
   output logic        ADC_TIMEOUT
);

   localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES);
   localparam logic [7:0] TIMEOUT_LAST = 8'(CONV_TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CONV,
      STORE
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  chen_lat, chen_lat_nxt;
   // Shared cycle counter: 1-based within SETTLE and within CONV
   // (the ADC_START cycle is CONV cycle 1).
   logic [7:0]  cnt, cnt_nxt;

   logic        adc_start_nxt;
   logic [7:0]  atmchsel_nxt;
   logic [15:0] result_nxt;
   logic        done_nxt;
   logic        lastword_nxt;
   logic        seq_busy_nxt;
   logic        frame_missed_nxt;
   logic        adc_timeout_nxt;

   logic        frame_start;
   logic        settle_done;
   logic        conv_expired;
   logic [7:0]  first_sel;
   logic [7:0]  higher_mask;
   logic [7:0]  next_sel;
   logic        sel_is_last;

   assign frame_start  = FRAME_TRIG && (CHEN != '0);
   assign settle_done  = (cnt == SETTLE_LAST);
   assign conv_expired = (cnt == TIMEOUT_LAST);

   // x & -x isolates the lowest set bit.
   assign first_sel    = CHEN & (~CHEN + 8'd1);
   // Latched channels strictly above the current one-hot select; for bit 7
   // the shift wraps to 0 and the mask correctly becomes empty.
   assign higher_mask  = chen_lat & ~(8'(ATMCHSEL << 1) - 8'd1);
   assign next_sel     = higher_mask & (~higher_mask + 8'd1);
   assign sel_is_last  = (higher_mask == '0);

   // State register (and all registered outputs)
   always_ff @(posedge SAMPLE_CLK or negedge NRST_sync) begin
      if (!NRST_sync) begin
         state        <= IDLE;
         chen_lat     <= '0;
         cnt          <= '0;
         ADC_START    <= 1'b0;
         ATMCHSEL     <= '0;
         RESULT       <= '0;
         DONE         <= 1'b0;
         LASTWORD     <= 1'b0;
         SEQ_BUSY     <= 1'b0;
         FRAME_MISSED <= 1'b0;
         ADC_TIMEOUT  <= 1'b0;
      end else begin
         state        <= state_nxt;
         chen_lat     <= chen_lat_nxt;
         cnt          <= cnt_nxt;
         ADC_START    <= adc_start_nxt;
         ATMCHSEL     <= atmchsel_nxt;
         RESULT       <= result_nxt;
         DONE         <= done_nxt;
         LASTWORD     <= lastword_nxt;
         SEQ_BUSY     <= seq_busy_nxt;
         FRAME_MISSED <= frame_missed_nxt;
         ADC_TIMEOUT  <= adc_timeout_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      chen_lat_nxt = chen_lat;
      if (!ENSAMP_sync) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (frame_start) begin
                  state_nxt    = SETTLE;
                  cnt_nxt      = 8'd1;
                  chen_lat_nxt = CHEN;
               end
            end
            SETTLE: begin
               if (settle_done) begin
                  state_nxt = CONV;
                  cnt_nxt   = 8'd1;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
            CONV: begin
               if (ADC_EOC || conv_expired) begin
                  state_nxt = STORE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 8'd1;
               end
            end
            STORE: begin
               if (LASTWORD) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = SETTLE;
                  cnt_nxt   = 8'd1;
               end
            end
            default: begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // Output logic: computes the value each output takes after the next edge,
   // so every output comes straight from a flop.
   always_comb begin
      adc_start_nxt    = 1'b0;
      done_nxt         = 1'b0;
      lastword_nxt     = 1'b0;
      atmchsel_nxt     = ATMCHSEL;
      result_nxt       = RESULT;
      frame_missed_nxt = FRAME_MISSED;
      adc_timeout_nxt  = ADC_TIMEOUT;
      seq_busy_nxt     = (state_nxt != IDLE);
      if (!ENSAMP_sync) begin
         atmchsel_nxt = '0;
         result_nxt   = '0;
      end else begin
         if (FRAME_TRIG && (state != IDLE)) begin
            frame_missed_nxt = ~FRAME_MISSED;
         end
         case (state)
            IDLE: begin
               atmchsel_nxt = frame_start ? first_sel : '0;
            end
            SETTLE: begin
               adc_start_nxt = settle_done;
            end
            CONV: begin
               // EOC takes priority over a timeout landing in the same cycle.
               if (ADC_EOC) begin
                  result_nxt   = ADC_DOUT;
                  done_nxt     = 1'b1;
                  lastword_nxt = sel_is_last;
               end else if (conv_expired) begin
                  result_nxt      = '1;
                  adc_timeout_nxt = ~ADC_TIMEOUT;
                  done_nxt        = 1'b1;
                  lastword_nxt    = sel_is_last;
               end
            end
            STORE: begin
               atmchsel_nxt = LASTWORD ? '0 : next_sel;
            end
            default: begin
               atmchsel_nxt = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// tb_adc_channel_sequencer
//   Randomized frames against a frame-level reference model. Each frame plan
//   pushes the expected DONE words (select, data, last flag, cycle) into a
//   scoreboard queue and the per-conversion EOC delays into an ADC responder
//   queue; a monitor pops and compares whenever DONE is seen.
module tb_adc_channel_sequencer;

   localparam int S  = 2;
   localparam int TO = 20;

   logic        SAMPLE_CLK;
   logic        NRST_sync;
   logic        ENSAMP_sync;
   logic        FRAME_TRIG;
   logic [7:0]  CHEN;
   logic        ADC_EOC;
   logic [15:0] ADC_DOUT;
   logic        ADC_START;
   logic [7:0]  ATMCHSEL;
   logic [15:0] RESULT;
   logic        DONE;
   logic        LASTWORD;
   logic        SEQ_BUSY;
   logic        FRAME_MISSED;
   logic        ADC_TIMEOUT;

   adc_channel_sequencer #(
      .SETTLE_CYCLES(S),
      .CONV_TIMEOUT (TO)
   ) dut (
      .SAMPLE_CLK  (SAMPLE_CLK),
      .NRST_sync   (NRST_sync),
      .ENSAMP_sync (ENSAMP_sync),
      .FRAME_TRIG  (FRAME_TRIG),
      .CHEN        (CHEN),
      .ADC_EOC     (ADC_EOC),
      .ADC_DOUT    (ADC_DOUT),
      .ADC_START   (ADC_START),
      .ATMCHSEL    (ATMCHSEL),
      .RESULT      (RESULT),
      .DONE        (DONE),
      .LASTWORD    (LASTWORD),
      .SEQ_BUSY    (SEQ_BUSY),
      .FRAME_MISSED(FRAME_MISSED),
      .ADC_TIMEOUT (ADC_TIMEOUT)
   );

   initial SAMPLE_CLK = 1'b0;
   always #5 SAMPLE_CLK = ~SAMPLE_CLK;

   // Cycle index: after edge m (sampled #1 later) we are in cycle m.
   int cyc = 0;
   always @(posedge SAMPLE_CLK) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  sel;
      logic [15:0] res;
      logic        last;
      int          at;
   } done_t;

   typedef struct {
      int          k;   // CONV cycle carrying EOC (1 = ADC_START cycle); 0 = never
      logic [15:0] d;
   } conv_t;

   done_t       sb_q[$];
   conv_t       adc_q[$];
   int          n_pass  = 0;
   int          n_total = 0;
   logic        exp_fm  = 1'b0;
   logic        exp_to  = 1'b0;
   int          fr_k[8];
   logic [15:0] fr_d[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge SAMPLE_CLK);
      #1;
   endtask

   // Monitor: select encoding every cycle, scoreboard on DONE.
   initial begin
      done_t e;
      forever begin
         tick();
         if (SEQ_BUSY) check("sel_onehot_busy", 32'($onehot(ATMCHSEL)), 32'd1);
         else          check("sel_zero_idle", 32'(ATMCHSEL), 32'd0);
         if (DONE) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("done_sel", 32'(ATMCHSEL), 32'(e.sel));
               check("done_result", 32'(RESULT), 32'(e.res));
               check("done_last", 32'(LASTWORD), 32'(e.last));
               check("done_cycle", 32'(cyc), 32'(e.at));
            end
         end
      end
   end

   // ADC model: answers each ADC_START with EOC in CONV cycle k.
   initial begin
      conv_t c;
      ADC_EOC  = 1'b0;
      ADC_DOUT = '0;
      forever begin
         tick();
         if (ADC_START) begin
            if (adc_q.size() == 0) begin
               check("unexpected_adc_start", 32'd1, 32'd0);
            end else begin
               c = adc_q.pop_front();
               if (c.k != 0) begin
                  repeat (c.k - 1) tick();
                  ADC_EOC  = 1'b1;
                  ADC_DOUT = c.d;
                  tick();
                  ADC_EOC  = 1'b0;
               end
            end
         end
         ADC_DOUT = 16'($urandom);
      end
   end

   function automatic int pick_k();
      int r;
      r = int'($urandom_range(9));
      case (r)
         0:       return 0;
         1:       return TO;
         2:       return TO + 1;   // EOC lands in STORE: must be ignored
         3:       return TO - 1;
         default: return int'($urandom_range(6, 1));
      endcase
   endfunction

   task automatic randomize_frame();
      for (int i = 0; i < 8; i++) begin
         fr_k[i] = pick_k();
         fr_d[i] = 16'($urandom);
      end
   endtask

   // Reference model: channels in ascending order, each taking S settle
   // cycles, min(k, TO) conversion cycles and one store cycle.
   task automatic plan(input logic [7:0] mask, input int n, input int lim, output int last_at);
      int    t;
      int    used;
      int    keff;
      logic  hit;
      done_t e;
      conv_t c;
      t       = n + 1;
      used    = 0;
      last_at = n;
      for (int i = 0; i < 8; i++) begin
         if (mask[i] && used < lim) begin
            hit    = (fr_k[i] != 0) && (fr_k[i] <= TO);
            keff   = hit ? fr_k[i] : TO;
            e.sel  = 8'(1 << i);
            e.res  = hit ? fr_d[i] : 16'hFFFF;
            e.last = ((mask >> (i + 1)) == 8'h00);
            e.at   = t + S + keff;
            sb_q.push_back(e);
            c.k = fr_k[i];
            c.d = fr_d[i];
            adc_q.push_back(c);
            if (!hit) exp_to = ~exp_to;
            last_at = e.at;
            t       = e.at + 1;
            used++;
         end
      end
   endtask

   task automatic end_of_frame_checks(input string tag);
      check({tag, "_busy_low"}, 32'(SEQ_BUSY), 32'd0);
      check({tag, "_sel_zero"}, 32'(ATMCHSEL), 32'd0);
      check({tag, "_frame_missed"}, 32'(FRAME_MISSED), 32'(exp_fm));
      check({tag, "_adc_timeout"}, 32'(ADC_TIMEOUT), 32'(exp_to));
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
      check({tag, "_adc_q_empty"}, 32'(adc_q.size()), 32'd0);
      sb_q.delete();
      adc_q.delete();
   endtask

   // Issues FRAME_TRIG this cycle and runs until the cycle after the final
   // DONE. 'extra' stray triggers land on random busy cycles.
   task automatic run_frame(input logic [7:0] mask, input int extra,
                            input logic scramble, input logic trig_last);
      int n;
      int fin;
      int left;
      int rem;
      n           = cyc;
      CHEN        = mask;
      ENSAMP_sync = 1'b1;
      FRAME_TRIG  = 1'b1;
      plan(mask, n, 8, fin);
      left = extra;
      while (cyc < fin + 1) begin
         tick();
         FRAME_TRIG = 1'b0;
         if (scramble) CHEN = 8'($urandom);
         if (cyc <= fin) begin
            rem = fin - cyc + 1;
            if (left > 0 && int'($urandom_range(rem - 1)) < left) begin
               FRAME_TRIG = 1'b1;
               left--;
            end else if (trig_last && cyc == fin) begin
               FRAME_TRIG = 1'b1;
            end
            if (FRAME_TRIG) exp_fm = ~exp_fm;
         end
      end
      end_of_frame_checks("frame");
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish within time limit");
      $fatal(1);
   end

   initial begin
      int guard;
      NRST_sync   = 1'b0;
      ENSAMP_sync = 1'b0;
      FRAME_TRIG  = 1'b0;
      CHEN        = '0;
      repeat (3) tick();
      check("reset_outputs", {ADC_START, ATMCHSEL, RESULT, DONE, LASTWORD,
                              SEQ_BUSY, FRAME_MISSED, ADC_TIMEOUT}, '0);
      @(negedge SAMPLE_CLK);
      NRST_sync = 1'b1;
      repeat (2) tick();
      check("post_reset_idle", 32'(SEQ_BUSY), 32'd0);

      // Two-channel frame, EOC 3 cycles after ADC_START.
      randomize_frame();
      fr_k[0] = 4; fr_d[0] = 16'h1234;
      fr_k[2] = 4; fr_d[2] = 16'hABCD;
      run_frame(8'h05, 0, 1'b0, 1'b0);

      // Single top channel, never answered.
      randomize_frame();
      fr_k[7] = 0;
      run_frame(8'h80, 0, 1'b0, 1'b0);

      // Two stray triggers mid-frame, then one in the final STORE cycle.
      randomize_frame();
      run_frame(8'h5A, 2, 1'b0, 1'b0);
      randomize_frame();
      run_frame(8'h81, 0, 1'b0, 1'b1);

      // CHEN churn during a frame, then the next frame uses the new mask.
      randomize_frame();
      run_frame(8'h03, 0, 1'b1, 1'b0);
      randomize_frame();
      run_frame(8'hF0, 0, 1'b0, 1'b0);

      // Abort during channel 3 conversion of a full frame.
      randomize_frame();
      for (int i = 0; i < 3; i++) fr_k[i] = int'($urandom_range(4, 1));
      fr_k[3] = 0;
      begin
         int    fin;
         conv_t c;
         CHEN        = 8'hFF;
         ENSAMP_sync = 1'b1;
         FRAME_TRIG  = 1'b1;
         plan(8'hFF, cyc, 3, fin);
         c.k = 0;
         c.d = '0;
         adc_q.push_back(c);
      end
      tick();
      FRAME_TRIG = 1'b0;
      CHEN       = 8'h00;
      guard      = 0;
      while (!(ADC_START && ATMCHSEL == 8'h08) && guard < 200) begin
         tick();
         guard++;
      end
      check("abort_reached_ch3", 32'(ADC_START && ATMCHSEL == 8'h08), 32'd1);
      ENSAMP_sync = 1'b0;
      tick();
      check("abort_outputs_zero", {ADC_START, ATMCHSEL, RESULT, DONE, LASTWORD, SEQ_BUSY}, '0);
      check("abort_fm_hold", 32'(FRAME_MISSED), 32'(exp_fm));
      check("abort_to_hold", 32'(ADC_TIMEOUT), 32'(exp_to));
      repeat (10) tick();
      FRAME_TRIG = 1'b1;
      CHEN       = 8'hFF;
      tick();
      FRAME_TRIG = 1'b0;
      tick();
      end_of_frame_checks("abort");
      randomize_frame();
      run_frame(8'hFF, 0, 1'b0, 1'b0);

      // Reset during SETTLE, then a trigger with an empty mask.
      randomize_frame();
      CHEN        = 8'h21;
      ENSAMP_sync = 1'b1;
      FRAME_TRIG  = 1'b1;
      tick();
      FRAME_TRIG = 1'b0;
      check("pre_reset_busy", 32'(SEQ_BUSY), 32'd1);
      #2;
      NRST_sync = 1'b0;
      #1;
      check("async_reset_outputs", {ADC_START, ATMCHSEL, RESULT, DONE, LASTWORD,
                                    SEQ_BUSY, FRAME_MISSED, ADC_TIMEOUT}, '0);
      sb_q.delete();
      adc_q.delete();
      exp_fm = 1'b0;
      exp_to = 1'b0;
      @(negedge SAMPLE_CLK);
      NRST_sync = 1'b1;
      tick();
      CHEN       = 8'h00;
      FRAME_TRIG = 1'b1;
      tick();
      FRAME_TRIG = 1'b0;
      repeat (4) tick();
      end_of_frame_checks("empty_mask");

      // Randomized frames.
      for (int f = 0; f < 25; f++) begin
         randomize_frame();
         run_frame(8'($urandom_range(255, 1)), int'($urandom_range(2)),
                   1'($urandom_range(1)), ($urandom_range(3) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/adc_channel_sequencer.md
ADC_CHANNEL_SEQUENCER -- requirements
Module: adc_channel_sequencer

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: mux settle cycles before each conversion start; legal range 1..15.
REQ-002 Parameter CONV_TIMEOUT, default 64: maximum cycles from ADC_START to ADC_EOC; legal range 2..255.
REQ-003 SAMPLE_CLK  in  1: sole clock; all logic on its rising edge.
REQ-004 NRST_sync  in  1: asynchronous, active-low reset.
REQ-005 ENSAMP_sync  in  1: sampling enable, already synchronous to SAMPLE_CLK.
REQ-006 FRAME_TRIG  in  1: single-cycle frame-start tick.
REQ-007 CHEN  in  8: channel enable mask; bit n enables channel n.
REQ-008 ADC_EOC  in  1: SAR end-of-conversion, single-cycle, synchronous.
REQ-009 ADC_DOUT  in  16: SAR result, valid in the ADC_EOC cycle.
REQ-010 ADC_START  out  1: single-cycle conversion start pulse.
REQ-011 ATMCHSEL  out  8: one-hot analog mux select / FIFO word select.
REQ-012 RESULT  out  16: conversion result presented to the FIFO.
REQ-013 DONE  out  1: single-cycle result-valid strobe to the FIFO.
REQ-014 LASTWORD  out  1: high with DONE on the frame's final channel.
REQ-015 SEQ_BUSY  out  1: high in any state other than IDLE.
REQ-016 FRAME_MISSED  out  1: event toggle; inverts once per dropped FRAME_TRIG.
REQ-017 ADC_TIMEOUT  out  1: event toggle; inverts once per conversion timeout.

Function
REQ-018 The FSM SHALL have the states IDLE, SETTLE, CONV and STORE; all outputs SHALL be registered.
REQ-019 IDLE: FRAME_TRIG=1, ENSAMP_sync=1 and CHEN!=0 at cycle T SHALL latch CHEN into chen_lat, drive ATMCHSEL to the lowest set bit, and enter SETTLE at T+1; otherwise the block SHALL remain in IDLE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter CONV with ADC_START=1 in the first CONV cycle only.
REQ-021 CONV: ADC_EOC=1 SHALL capture ADC_DOUT into RESULT and enter STORE on the next cycle; ADC_EOC SHALL be honoured from the first CONV cycle onward.
REQ-022 CONV: if CONV_TIMEOUT cycles elapse, counting the ADC_START cycle as 1, without ADC_EOC, the block SHALL set RESULT=16'hFFFF, toggle ADC_TIMEOUT, and enter STORE.
REQ-023 If ADC_EOC coincides with the timeout cycle, ADC_EOC SHALL win: real data is stored and there is no toggle.
REQ-024 STORE SHALL last one cycle, with DONE=1 and LASTWORD=1 iff no higher-index bit is set in chen_lat; RESULT and ATMCHSEL SHALL be stable and valid in that cycle.
REQ-025 After STORE, the block SHALL go to IDLE if LASTWORD=1; otherwise it SHALL move ATMCHSEL to the next higher set bit of chen_lat and enter SETTLE.
REQ-026 ATMCHSEL SHALL be exactly one-hot from SETTLE through STORE and 8'h00 in IDLE.
REQ-027 CHEN changes after the latch cycle SHALL NOT affect the frame in progress.
REQ-028 A FRAME_TRIG while SEQ_BUSY=1 SHALL toggle FRAME_MISSED and be otherwise ignored; a FRAME_TRIG in the STORE cycle with LASTWORD=1 also counts as missed.
REQ-029 ADC_EOC outside CONV SHALL be ignored.
REQ-030 ENSAMP_sync=0 in any state SHALL force IDLE on the next edge with ADC_START, DONE, LASTWORD, ATMCHSEL and RESULT at 0, and no DONE for the aborted frame; FRAME_MISSED and ADC_TIMEOUT SHALL hold their values.
REQ-031 Per-channel latency SHALL be SETTLE_CYCLES + k + 1 cycles from SETTLE entry to the DONE cycle, where k is the number of CONV cycles up to and including the ADC_EOC cycle.
REQ-032 Consecutive DONE pulses SHALL be separated by at least SETTLE_CYCLES+1 cycles.

Reset
REQ-033 NRST_sync=0 SHALL immediately force IDLE, all outputs to 0, and chen_lat and all counters to 0.
REQ-034 Reset deassertion SHALL take effect on the next SAMPLE_CLK edge, with no spurious ADC_START or DONE.

Verification
REQ-035 CHEN=8'h05, SETTLE_CYCLES=2, ADC_EOC 3 cycles after ADC_START with ADC_DOUT 16'h1234 then 16'hABCD -> two DONE pulses: ATMCHSEL 8'h01, RESULT 16'h1234, LASTWORD=0; then ATMCHSEL 8'h04, RESULT 16'hABCD, LASTWORD=1; then IDLE.
REQ-036 CHEN=8'h80 with ADC_EOC never asserted -> DONE after CONV_TIMEOUT cycles with RESULT 16'hFFFF, LASTWORD=1, and ADC_TIMEOUT toggled once.
REQ-037 FRAME_TRIG repeated mid-frame twice -> FRAME_MISSED toggles twice (net 0), and the frame completes normally.
REQ-038 ENSAMP_sync dropped during CONV of channel 3 of CHEN=8'hFF -> no further DONE, and IDLE with outputs 0 on the next cycle; re-enable plus FRAME_TRIG -> a full 8-word frame starting at ATMCHSEL 8'h01.
REQ-039 CHEN changed from 8'h03 to 8'hF0 during a frame -> channels 0 and 1 only; the next frame uses 8'hF0.
REQ-040 NRST_sync asserted during SETTLE -> all outputs 0 immediately; FRAME_TRIG=1 with CHEN=8'h00 -> remains in IDLE, no toggle.
